// File: rtl/maxpool_stream_11.sv
// rtl/maxpool_stream_11.sv - streaming 1-D signed max-pool over non-overlapping windows of P samples
// Define MAXPOOL_IDX_EN to add the y_idx port reporting the frame index of each window's maximum.
module maxpool_stream_11 #(
  parameter int W = 11,
  parameter int N = 22,
  parameter int P = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W-1:0]  x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic signed [W-1:0]  y_data,
  output logic                 y_valid,
  input  logic                 y_ready
`ifdef MAXPOOL_IDX_EN
  ,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] y_idx
`endif
);
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         win_cnt;
  logic [FW-1:0]         frm_cnt;
  logic signed [W-1:0]   max_r;
  logic signed [W-1:0]   cand;
  logic                  accept;
  logic                  close;
  logic                  take_new;
  logic                  frm_last;

  // Strict greater-than so a tie keeps the earlier sample.
  assign take_new = (win_cnt == '0) || (x_data > max_r);
  assign cand     = take_new ? x_data : max_r;
  assign frm_last = (frm_cnt == FW'(N - 1));
  assign accept   = x_valid && x_ready;
  assign close    = accept && ((win_cnt == CW'(P - 1)) || frm_last);

  always_comb begin
    state_nxt = state;
    x_ready   = (state == ACC) || y_ready;
    y_valid   = (state == OUT);
    case (state)
      ACC:     if (close) state_nxt = OUT;
      OUT:     if (y_ready) state_nxt = close ? OUT : ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt <= '0;
      frm_cnt <= '0;
      max_r   <= '0;
      y_data  <= '0;
    end else if (accept) begin
      max_r   <= cand;
      frm_cnt <= frm_last ? '0 : frm_cnt + 1'b1;
      if (close) begin
        win_cnt <= '0;
        y_data  <= cand;
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

`ifdef MAXPOOL_IDX_EN
  logic [FW-1:0] idx_r;
  logic [FW-1:0] cand_idx;

  assign cand_idx = take_new ? frm_cnt : idx_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r <= '0;
      y_idx <= '0;
    end else if (accept) begin
      idx_r <= cand_idx;
      if (close) y_idx <= cand_idx;
    end
  end
`endif

endmodule

// File: tb/tb_maxpool_stream_11.sv
// tb/tb_maxpool_stream_11.sv - directed bench for maxpool_stream_11 (N=22 and N=5 instances, P=2)
module tb_maxpool_stream_11;
  logic              clk;
  logic              rst_n;
  logic signed [10:0] x_data;
  logic              x_valid;
  logic              y_ready;
  logic              sel;

  logic              xa_valid, xb_valid;
  logic              xa_ready, xb_ready;
  logic signed [10:0] ya_data, yb_data;
  logic              ya_valid, yb_valid;
  logic [4:0]        ya_idx;
  logic [2:0]        yb_idx;

  logic              x_ready_s, y_valid_s;
  logic signed [10:0] y_data_s;
  logic [4:0]        y_idx_s;

  int checks = 0;
  int errors = 0;

  logic signed [10:0] in_q[$];
  logic signed [10:0] out_q[$];
  int                 out_idx[$];
  int                 out_cyc[$];
  int                 acc_cyc[$];
  int                 unstable;
  int                 xr_low;

  assign xa_valid  = x_valid && !sel;
  assign xb_valid  = x_valid && sel;
  assign x_ready_s = sel ? xb_ready : xa_ready;
  assign y_valid_s = sel ? yb_valid : ya_valid;
  assign y_data_s  = sel ? yb_data : ya_data;
`ifdef MAXPOOL_IDX_EN
  assign y_idx_s   = sel ? {2'b00, yb_idx} : ya_idx;
`else
  assign ya_idx    = '0;
  assign yb_idx    = '0;
  assign y_idx_s   = '0;
`endif

  maxpool_stream_11 #(.W(11), .N(22), .P(2)) u_dut (
    .clk     (clk),
    .reset   (rst_n),
    .x_data  (x_data),
    .x_valid (xa_valid),
    .x_ready (xa_ready),
    .y_data  (ya_data),
    .y_valid (ya_valid),
    .y_ready (y_ready)
`ifdef MAXPOOL_IDX_EN
    ,
    .y_idx   (ya_idx)
`endif
  );

  maxpool_stream_11 #(.W(11), .N(5), .P(2)) u_dut5 (
    .clk     (clk),
    .reset   (rst_n),
    .x_data  (x_data),
    .x_valid (xb_valid),
    .x_ready (xb_ready),
    .y_data  (yb_data),
    .y_valid (yb_valid),
    .y_ready (y_ready)
`ifdef MAXPOOL_IDX_EN
    ,
    .y_idx   (yb_idx)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Feeds in_q back-to-back, y_ready low for cycles [stall_from, stall_from+stall_len).
  task automatic run_stream(input int exp_outs, input int stall_from, input int stall_len, input int limit);
    int i;
    int cyc;
    logic signed [10:0] prev;
    logic prev_hold;
    i = 0;
    cyc = 0;
    prev = '0;
    prev_hold = 1'b0;
    out_q.delete();
    out_idx.delete();
    out_cyc.delete();
    acc_cyc.delete();
    unstable = 0;
    xr_low = 0;
    while ((i < in_q.size() || out_q.size() < exp_outs) && cyc < limit) begin
      @(negedge clk);
      x_valid = (i < in_q.size());
      x_data  = x_valid ? in_q[i] : '0;
      y_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      #1;
      if (prev_hold && y_data_s !== prev) unstable++;
      if (y_valid_s && y_ready) begin
        out_q.push_back(y_data_s);
        out_idx.push_back(int'(y_idx_s));
        out_cyc.push_back(cyc);
      end
      if (x_valid && x_ready_s) begin
        acc_cyc.push_back(cyc);
        i++;
      end
      if (x_valid && !x_ready_s) xr_low++;
      prev_hold = y_valid_s && !y_ready;
      prev = y_data_s;
      cyc++;
    end
    x_valid = 1'b0;
    x_data  = '0;
  endtask

  task automatic load_ramp();
    in_q.delete();
    for (int k = 0; k < 22; k++) in_q.push_back(11'(k));
  endtask

  task automatic test_reset();
    #12;
    checks++; if (y_valid_s !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %0b expected 0", y_valid_s); end
    checks++; if (y_data_s !== 11'sd0) begin errors++; $display("FAIL reset_y_data: got %0d expected 0", y_data_s); end
    checks++; if (x_ready_s !== 1'b1) begin errors++; $display("FAIL reset_x_ready: got %0b expected 1", x_ready_s); end
`ifdef MAXPOOL_IDX_EN
    checks++; if (y_idx_s !== 5'd0) begin errors++; $display("FAIL reset_y_idx: got %0d expected 0", y_idx_s); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp(input string tag);
    load_ramp();
    run_stream(11, 1000, 0, 200);
    checks++; if (out_q.size() != 11) begin errors++; $display("FAIL %s_count: got %0d expected 11", tag, out_q.size()); end
    for (int k = 0; k < 11 && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== 11'(2 * k + 1)) begin errors++; $display("FAIL %s_y[%0d]: got %0d expected %0d", tag, k, out_q[k], 2 * k + 1); end
`ifdef MAXPOOL_IDX_EN
      checks++;
      if (out_idx[k] != 2 * k + 1) begin errors++; $display("FAIL %s_idx[%0d]: got %0d expected %0d", tag, k, out_idx[k], 2 * k + 1); end
`endif
    end
    if (out_cyc.size() == 11) begin
      checks++; if (out_cyc[0] != 2) begin errors++; $display("FAIL %s_first_latency: got cycle %0d expected 2", tag, out_cyc[0]); end
      checks++; if (out_cyc[10] != 22) begin errors++; $display("FAIL %s_throughput: got last cycle %0d expected 22", tag, out_cyc[10]); end
    end
  endtask

  task automatic test_signed();
    int v[6] = '{-5, -3, -1024, 1023, 7, 7};
    int e[11] = '{-3, 1023, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    int ei[11] = '{1, 3, 4, 6, 8, 10, 12, 14, 16, 18, 20};
    in_q.delete();
    for (int k = 0; k < 6; k++) in_q.push_back(11'(v[k]));
    for (int k = 6; k < 22; k++) in_q.push_back('0);
    run_stream(11, 1000, 0, 200);
    checks++; if (out_q.size() != 11) begin errors++; $display("FAIL signed_count: got %0d expected 11", out_q.size()); end
    for (int k = 0; k < 11 && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== 11'(e[k])) begin errors++; $display("FAIL signed_y[%0d]: got %0d expected %0d", k, out_q[k], e[k]); end
`ifdef MAXPOOL_IDX_EN
      checks++;
      if (out_idx[k] != ei[k]) begin errors++; $display("FAIL signed_idx[%0d]: got %0d expected %0d", k, out_idx[k], ei[k]); end
`endif
    end
  endtask

  task automatic test_backpressure();
    load_ramp();
    run_stream(11, 2, 10, 300);
    checks++; if (out_q.size() != 11) begin errors++; $display("FAIL bp_count: got %0d expected 11", out_q.size()); end
    for (int k = 0; k < 11 && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== 11'(2 * k + 1)) begin errors++; $display("FAIL bp_y[%0d]: got %0d expected %0d", k, out_q[k], 2 * k + 1); end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes expected 0", unstable); end
    checks++; if (xr_low != 10) begin errors++; $display("FAIL bp_x_ready_low: got %0d cycles expected 10", xr_low); end
    if (out_cyc.size() > 0 && acc_cyc.size() > 2) begin
      checks++; if (out_cyc[0] != 12) begin errors++; $display("FAIL bp_release_out: got cycle %0d expected 12", out_cyc[0]); end
      checks++; if (acc_cyc[2] != 12) begin errors++; $display("FAIL bp_release_accept: got cycle %0d expected 12", acc_cyc[2]); end
    end
  endtask

  task automatic test_partial_and_back_to_back();
    int v[5] = '{4, 9, 2, 8, 6};
    int e[6] = '{9, 8, 6, 9, 8, 6};
    int ei[6] = '{1, 3, 4, 1, 3, 4};
    int ec[6] = '{2, 4, 5, 7, 9, 10};
    sel = 1'b1;
    in_q.delete();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 5; k++) in_q.push_back(11'(v[k]));
    run_stream(6, 1000, 0, 100);
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL n5_count: got %0d expected 6", out_q.size()); end
    for (int k = 0; k < 6 && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== 11'(e[k])) begin errors++; $display("FAIL n5_y[%0d]: got %0d expected %0d", k, out_q[k], e[k]); end
      checks++;
      if (out_cyc[k] != ec[k]) begin errors++; $display("FAIL n5_cycle[%0d]: got %0d expected %0d", k, out_cyc[k], ec[k]); end
`ifdef MAXPOOL_IDX_EN
      checks++;
      if (out_idx[k] != ei[k]) begin errors++; $display("FAIL n5_idx[%0d]: got %0d expected %0d", k, out_idx[k], ei[k]); end
`endif
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    in_q.delete();
    for (int k = 0; k < 4; k++) in_q.push_back(11'(k + 40));
    run_stream(1, 0, 100, 4);
    @(negedge clk);
    #1;
    checks++; if (y_valid_s !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b expected 1", y_valid_s); end
    checks++; if (y_data_s !== 11'sd41) begin errors++; $display("FAIL mid_pre_data: got %0d expected 41", y_data_s); end
    rst_n = 1'b0;
    #1;
    checks++; if (y_valid_s !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %0b expected 0", y_valid_s); end
    checks++; if (y_data_s !== 11'sd0) begin errors++; $display("FAIL mid_async_data: got %0d expected 0", y_data_s); end
    checks++; if (x_ready_s !== 1'b1) begin errors++; $display("FAIL mid_async_x_ready: got %0b expected 1", x_ready_s); end
    @(negedge clk);
    rst_n = 1'b1;
    y_ready = 1'b1;
    test_ramp("after_reset");
  endtask

  initial begin
    rst_n   = 1'b0;
    x_data  = '0;
    x_valid = 1'b0;
    y_ready = 1'b1;
    sel     = 1'b0;
    test_reset();
    test_ramp("ramp");
    test_backpressure();
    test_signed();
    test_partial_and_back_to_back();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
